// File: rtl/mem_req_pkg.sv
// mem_req_pkg
//   Shared types and constants for the 16-bit memory requester:
//   FSM state encoding, memory byte-lane enables and the load
//   extension mode encoding.
package mem_req_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  // Byte-lane enables; bit [1] is the high byte of the memory word.
  localparam logic [1:0] BE_WORD = 2'b11;
  localparam logic [1:0] BE_LO   = 2'b01;
  localparam logic [1:0] BE_HI   = 2'b10;

  // Load extension mode for byte loads.
  localparam logic EXT_ZERO = 1'b0;
  localparam logic EXT_SIGN = 1'b1;

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align
//   Combinational byte-lane logic for a 16-bit memory port.
//   Store side: byte enables and lane-replicated write data.
//   Load side : byte select by address bit 0 plus zero/sign extension.
// Ports:
//   st_write, st_byte, st_addr0, st_wdata -> st_byte_enable, st_wdata_lane
//   ld_byte, ld_addr0, ld_ext, ld_rdata   -> ld_data
module mem_lane_align
  import mem_req_pkg::*;
(
  input  logic        st_write,
  input  logic        st_byte,
  input  logic        st_addr0,
  input  logic [15:0] st_wdata,
  output logic [1:0]  st_byte_enable,
  output logic [15:0] st_wdata_lane,
  input  logic        ld_byte,
  input  logic        ld_addr0,
  input  logic        ld_ext,
  input  logic [15:0] ld_rdata,
  output logic [15:0] ld_data
);

  logic [7:0] ld_sel;

  always_comb begin
    st_byte_enable = BE_WORD;
    st_wdata_lane  = st_wdata;
    // Only byte stores narrow the enables; loads fetch the whole word and
    // pick the byte on return.
    if (st_write && st_byte) begin
      st_byte_enable = st_addr0 ? BE_HI : BE_LO;
      st_wdata_lane  = {st_wdata[7:0], st_wdata[7:0]};
    end
  end

  always_comb begin
    ld_sel  = ld_addr0 ? ld_rdata[15:8] : ld_rdata[7:0];
    ld_data = ld_rdata;
    if (ld_byte) begin
      ld_data = {{8{(ld_ext == EXT_SIGN) && ld_sel[7]}}, ld_sel};
    end
  end

endmodule

// File: rtl/mem_requester.sv
// mem_requester
//   Initiator for a 16-bit request/response memory port. Takes one
//   load/store from the core, drives registered memory strobes until the
//   memory answers with mem_resp, then returns one rsp_valid pulse with
//   aligned/extended read data. Misaligned word accesses error out
//   without touching memory; a watchdog aborts accesses the memory never
//   answers and then drains a possible late response.
// Ports:
//   clk, reset (async, active high)
//   core side  : req_valid/req_ready, req_write, req_byte, req_signed,
//                req_addr, req_wdata; rsp_valid, rsp_error, rsp_rdata
//   memory side: mem_read, mem_write, mem_byte_enable, mem_address,
//                mem_wdata; mem_resp, mem_rdata
module mem_requester
  import mem_req_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_byte,
  input  logic        req_signed,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic        rsp_error,
  output logic [15:0] rsp_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [1:0]  mem_byte_enable,
  output logic [15:0] mem_address,
  output logic [15:0] mem_wdata,
  input  logic        mem_resp,
  input  logic [15:0] mem_rdata
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  // The count before the edge on which the limit is reached.
  localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] WD_MAX  = CW'(TIMEOUT_CYCLES);

  state_t        state_reg;
  logic [CW-1:0] wd_count_reg;
  logic          write_reg;
  logic          byte_reg;
  logic          ext_reg;
  logic          addr0_reg;

  logic [1:0]    st_byte_enable;
  logic [15:0]   st_wdata_lane;
  logic [15:0]   ld_data;

  // Store steering works on the live request (captured at the accepting
  // edge); load selection works on the registered request fields.
  mem_lane_align u_align (
    .st_write       (req_write),
    .st_byte        (req_byte),
    .st_addr0       (req_addr[0]),
    .st_wdata       (req_wdata),
    .st_byte_enable (st_byte_enable),
    .st_wdata_lane  (st_wdata_lane),
    .ld_byte        (byte_reg),
    .ld_addr0       (addr0_reg),
    .ld_ext         (ext_reg),
    .ld_rdata       (mem_rdata),
    .ld_data        (ld_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      wd_count_reg    <= '0;
      write_reg       <= 1'b0;
      byte_reg        <= 1'b0;
      ext_reg         <= EXT_ZERO;
      addr0_reg       <= 1'b0;
      req_ready       <= 1'b0;
      rsp_valid       <= 1'b0;
      rsp_error       <= 1'b0;
      rsp_rdata       <= '0;
      mem_read        <= 1'b0;
      mem_write       <= 1'b0;
      mem_byte_enable <= '0;
      mem_address     <= '0;
      mem_wdata       <= '0;
    end else begin
      // Response outputs are single-cycle pulses unless set below.
      rsp_valid <= 1'b0;
      rsp_error <= 1'b0;
      rsp_rdata <= '0;

      case (state_reg)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready       <= 1'b0;
            write_reg       <= req_write;
            byte_reg        <= req_byte;
            ext_reg         <= req_signed ? EXT_SIGN : EXT_ZERO;
            addr0_reg       <= req_addr[0];
            mem_address     <= {req_addr[15:1], 1'b0};
            mem_byte_enable <= st_byte_enable;
            mem_wdata       <= st_wdata_lane;
            wd_count_reg    <= '0;
            if (!req_byte && req_addr[0]) begin
              // Misaligned word: answer with an error, never strobe memory.
              state_reg <= DONE;
              rsp_valid <= 1'b1;
              rsp_error <= 1'b1;
            end else begin
              state_reg <= ACCESS;
              mem_read  <= !req_write;
              mem_write <= req_write;
            end
          end
        end

        ACCESS: begin
          // mem_resp is tested first so it wins over a simultaneous timeout.
          if (mem_resp) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= write_reg ? 16'h0000 : ld_data;
            state_reg <= DONE;
          end else if (wd_count_reg == WD_LAST) begin
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            rsp_valid    <= 1'b1;
            rsp_error    <= 1'b1;
            wd_count_reg <= '0;
            state_reg    <= DRAIN;
          end else if (wd_count_reg != WD_MAX) begin
            wd_count_reg <= wd_count_reg + 1'b1;
          end
        end

        DONE: begin
          state_reg <= IDLE;
          req_ready <= 1'b1;
        end

        DRAIN: begin
          // A response here belongs to the aborted access and is dropped.
          if (mem_resp || (wd_count_reg == WD_LAST)) begin
            state_reg <= IDLE;
            req_ready <= 1'b1;
          end else if (wd_count_reg != WD_MAX) begin
            wd_count_reg <= wd_count_reg + 1'b1;
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_requester.sv
// tb_mem_requester
//   Self-checking bench for mem_requester: directed cases for word/byte
//   access, lane steering, misalignment, timeout/drain and reset during an
//   access, followed by randomized requests against a byte-array model.
module tb_mem_requester;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic        req_byte = 1'b0;
  logic        req_signed = 1'b0;
  logic [15:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_error;
  logic [15:0] rsp_rdata;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_byte_enable;
  logic [15:0] mem_address;
  logic [15:0] mem_wdata;
  logic        mem_resp = 1'b0;
  logic [15:0] mem_rdata = '0;

  // mem: the stub memory, written from the DUT's memory port.
  // ref_mem: reference view, written from request semantics only.
  logic [7:0] mem     [0:65535];
  logic [7:0] ref_mem [0:65535];

  int n_checks = 0;
  int n_fail   = 0;
  int txn_id   = 0;
  logic [15:0] last_rdata;
  logic        last_error;

  always #5 clk = ~clk;

  mem_requester #(.TIMEOUT_CYCLES(T)) dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_write       (req_write),
    .req_byte        (req_byte),
    .req_signed      (req_signed),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .rsp_valid       (rsp_valid),
    .rsp_error       (rsp_error),
    .rsp_rdata       (rsp_rdata),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_resp        (mem_resp),
    .mem_rdata       (mem_rdata)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one request and return #1 after the accepting edge, with the
  // request fields scrambled (they must be ignored from then on).
  task automatic launch(input bit wr, input bit bt, input bit sg,
                        input logic [15:0] addr, input logic [15:0] wdata);
    @(negedge clk);
    check_eq("ready_before", 64'(req_ready), 64'(1));
    req_valid  = 1'b1;
    req_write  = wr;
    req_byte   = bt;
    req_signed = sg;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_write  = 1'($urandom);
    req_byte   = 1'($urandom);
    req_signed = 1'($urandom);
    req_addr   = 16'($urandom);
    req_wdata  = 16'($urandom);
  endtask

  // lat >= 0: memory answers lat cycles after it first samples the strobe.
  // lat <  0: memory never answers. late in 1..T-1: stray mem_resp in that
  // DRAIN cycle after a timeout.
  task automatic run_txn(input bit wr, input bit bt, input bit sg,
                         input logic [15:0] addr, input logic [15:0] wdata,
                         input int lat, input int late);
    bit          mis, tmo, seen, done;
    int          cyc, j, exp_cyc, exp_len, a0i, ai, ma;
    logic [15:0] a0, exp_rd, exp_wd;
    logic [1:0]  exp_be;
    logic [7:0]  b;
    mis    = !bt && addr[0];
    tmo    = !mis && !(lat >= 0 && lat < T);
    a0     = {addr[15:1], 1'b0};
    a0i    = int'(a0);
    ai     = int'(addr);
    exp_be = (wr && bt) ? (addr[0] ? 2'b10 : 2'b01) : 2'b11;
    exp_wd = bt ? {wdata[7:0], wdata[7:0]} : wdata;
    if (wr || mis || tmo) begin
      exp_rd = 16'h0000;
    end else if (!bt) begin
      exp_rd = {ref_mem[a0i + 1], ref_mem[a0i]};
    end else begin
      b      = ref_mem[ai];
      exp_rd = sg ? {{8{b[7]}}, b} : {8'h00, b};
    end

    launch(wr, bt, sg, addr, wdata);
    txn_id++;

    if (mis) begin
      check_eq("mis_rsp", 64'({rsp_valid, rsp_error}), 64'(2'b11));
      check_eq("mis_rdata", 64'(rsp_rdata), 64'(0));
      check_eq("mis_strobe", 64'({mem_read, mem_write}), 64'(0));
      last_rdata = rsp_rdata;
      last_error = rsp_error;
      @(posedge clk);
      #1;
      check_eq("mis_after", 64'({rsp_valid, mem_read, mem_write, req_ready}), 64'(4'b0001));
    end else begin
      check_eq("strobe", 64'({mem_read, mem_write}), 64'({!wr, wr}));
      check_eq("address", 64'(mem_address), 64'(a0));
      check_eq("byte_en", 64'(mem_byte_enable), 64'(exp_be));
      if (wr) check_eq("wdata", 64'(mem_wdata), 64'(exp_wd));

      exp_cyc = tmo ? T : lat + 1;
      cyc  = 0;
      seen = 1'b0;
      while (!seen && cyc < T + 4) begin
        @(negedge clk);
        cyc++;
        if (!tmo && cyc == lat + 1) begin
          mem_resp = 1'b1;
          ma = int'(mem_address);
          if (mem_write) begin
            if (mem_byte_enable[0]) mem[ma] = mem_wdata[7:0];
            if (mem_byte_enable[1]) mem[ma + 1] = mem_wdata[15:8];
          end
          mem_rdata = mem_read ? {mem[ma + 1], mem[ma]} : 16'($urandom);
        end
        @(posedge clk);
        #1;
        mem_resp  = 1'b0;
        mem_rdata = 16'($urandom);
        if (rsp_valid) seen = 1'b1;
        else check_eq("hold", 64'({mem_read, mem_write, mem_byte_enable, mem_address}),
                      64'({!wr, wr, exp_be, a0}));
      end
      check_eq("rsp_cycle", 64'(cyc), 64'(exp_cyc));
      check_eq("rsp_error", 64'(rsp_error), 64'(tmo));
      check_eq("rsp_rdata", 64'(rsp_rdata), 64'(exp_rd));
      check_eq("strobe_drop", 64'({mem_read, mem_write}), 64'(0));
      last_rdata = rsp_rdata;
      last_error = rsp_error;

      if (!tmo) begin
        if (wr) begin
          if (bt) begin
            ref_mem[ai] = wdata[7:0];
          end else begin
            ref_mem[a0i]     = wdata[7:0];
            ref_mem[a0i + 1] = wdata[15:8];
          end
        end
        @(posedge clk);
        #1;
        check_eq("done_after", 64'({rsp_valid, req_ready}), 64'(2'b01));
      end else begin
        exp_len = (late > 0 && late < T) ? late : T;
        j    = 0;
        done = 1'b0;
        while (!done && j < T + 4) begin
          @(negedge clk);
          j++;
          if (j == late) begin
            mem_resp  = 1'b1;
            mem_rdata = 16'($urandom);
          end
          @(posedge clk);
          #1;
          mem_resp = 1'b0;
          check_eq("drain_quiet", 64'({rsp_valid, mem_read, mem_write}), 64'(0));
          if (req_ready) done = 1'b1;
        end
        check_eq("drain_len", 64'(j), 64'(exp_len));
      end
    end
    $display("txn %0d wr=%0d byte=%0d sgn=%0d addr=%04h lat=%0d rdata=%04h err=%0d",
             txn_id, wr, bt, sg, addr, lat, last_rdata, last_error);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "time limit");
  end

  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem[i]     = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    mem[16'h0010] = 8'h12; ref_mem[16'h0010] = 8'h12;
    mem[16'h0011] = 8'h34; ref_mem[16'h0011] = 8'h34;
    mem[16'h0020] = 8'h66; ref_mem[16'h0020] = 8'h66;
    mem[16'h0021] = 8'h55; ref_mem[16'h0021] = 8'h55;

    // Reset state: every output low while reset is held.
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_outs", {9'd0, req_ready, rsp_valid, rsp_error, rsp_rdata, mem_read,
                            mem_write, mem_byte_enable, mem_address, mem_wdata}, 64'(0));
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_eq("ready_after_reset", 64'(req_ready), 64'(1));

    // Directed cases.
    run_txn(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 2, 0);
    check_eq("plan_word_load", 64'(last_rdata), 64'(16'h3412));
    run_txn(1'b1, 1'b1, 1'b0, 16'h0021, 16'h00AB, 1, 0);
    run_txn(1'b0, 1'b0, 1'b0, 16'h0020, 16'h0000, 0, 0);
    check_eq("plan_after_bstore", 64'(last_rdata), 64'(16'hAB66));
    run_txn(1'b0, 1'b1, 1'b1, 16'h0021, 16'h0000, 3, 0);
    check_eq("plan_byte_signed", 64'(last_rdata), 64'(16'hFFAB));
    run_txn(1'b0, 1'b1, 1'b0, 16'h0021, 16'h0000, 1, 0);
    check_eq("plan_byte_unsigned", 64'(last_rdata), 64'(16'h00AB));
    run_txn(1'b0, 1'b1, 1'b1, 16'h0020, 16'h0000, 0, 0);
    check_eq("plan_byte_pos", 64'(last_rdata), 64'(16'h0066));
    run_txn(1'b0, 1'b0, 1'b0, 16'h0033, 16'h0000, 1, 0);
    check_eq("plan_misaligned", 64'({last_error, last_rdata}), 64'({1'b1, 16'h0000}));
    run_txn(1'b0, 1'b0, 1'b0, 16'h0100, 16'h0000, -1, 0);
    check_eq("plan_timeout", 64'(last_error), 64'(1));
    run_txn(1'b1, 1'b0, 1'b0, 16'h0102, 16'h1234, -1, 3);
    run_txn(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, T - 1, 0);
    check_eq("resp_beats_timeout", 64'({last_error, last_rdata}), 64'({1'b0, 16'h3412}));

    // Reset in the middle of an access.
    launch(1'b0, 1'b0, 1'b0, 16'h0040, 16'h0000);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    check_eq("reset_mid_outs", {9'd0, req_ready, rsp_valid, rsp_error, rsp_rdata, mem_read,
                                mem_write, mem_byte_enable, mem_address, mem_wdata}, 64'(0));
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_eq("ready_after_mid_reset", 64'(req_ready), 64'(1));
    run_txn(1'b0, 1'b0, 1'b0, 16'h0040, 16'h0000, 2, 0);

    // Randomized requests.
    for (int n = 0; n < 60; n++) begin
      int lat;
      int late;
      lat  = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, T - 1));
      late = int'($urandom_range(0, T + 1));
      run_txn(1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom), lat, late);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_requester.md
# mem_requester

Initiator side of the 16-bit memory request/response port. Accepts load/store requests from the core datapath, steers them onto the memory port (read/write, byte_enable, halfword-aligned address), holds the request stable until the memory's `resp` pulse, then returns aligned, extended read data. Adds misalignment detection and a response watchdog, so the datapath never stalls forever on a dead memory.

## Interface
- `TIMEOUT_CYCLES`, default 1023: maximum number of ACCESS cycles without `mem_resp`; also the length of the DRAIN window.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  core request present.
- `req_ready`  out  1  block can accept a request; high only in IDLE.
- `req_write`  in  1  1 = store, 0 = load.
- `req_byte`  in  1  1 = byte access, 0 = word access.
- `req_signed`  in  1  byte loads only: 1 = sign-extend, 0 = zero-extend.
- `req_addr`  in  16  byte address.
- `req_wdata`  in  16  store data; byte stores use bits [7:0].
- `rsp_valid`  out  1  one-cycle completion pulse; there is no backpressure.
- `rsp_error`  out  1  qualifies `rsp_valid`: misaligned access or timeout.
- `rsp_rdata`  out  16  load result; 0 for stores and errors.
- `mem_read`, `mem_write`  out  1 each  memory strobes; never both high.
- `mem_byte_enable`  out  2  lane enables; [1] is the high byte.
- `mem_address`  out  16  always `{req_addr[15:1],1'b0}`.
- `mem_wdata`  out  16  lane-steered store data.
- `mem_resp`  in  1  memory completion pulse.
- `mem_rdata`  in  16  memory read data, valid when `mem_resp` is high.

## Operation
- **States:** IDLE, ACCESS, DONE, DRAIN.
- **IDLE:** `req_ready`=1. On `req_valid`, all request fields are registered.
  - Misaligned request (word access with `req_addr[0]`=1): go to DONE with an error. No memory strobe is raised.
  - Otherwise: go to ACCESS and raise `mem_read` or `mem_write`.
- **ACCESS:** all `mem_*` outputs are registered and held constant until `mem_resp` is sampled high.
  - On `mem_resp`: capture `mem_rdata`, drop both strobes, go to DONE.
  - The watchdog counter increments each ACCESS cycle. Counter width is `$clog2(TIMEOUT_CYCLES+1)`; the counter saturates and clears on entry to ACCESS.
  - If the counter reaches `TIMEOUT_CYCLES` without `mem_resp`: drop the strobes, pulse `rsp_valid`+`rsp_error`, go to DRAIN.
  - If `mem_resp` and the timeout occur on the same edge, `mem_resp` wins and the access completes normally.
- **DONE:** `rsp_valid`=1 for exactly this cycle, then go to IDLE. This guarantees at least one idle cycle between memory accesses, covering the memory's respond turnaround.
- **DRAIN:** strobes stay low. Any `mem_resp` is discarded (it belongs to the aborted access). Leave for IDLE on `mem_resp` or after `TIMEOUT_CYCLES` cycles, whichever comes first.
- **Lane steering:**
  - Word access: `mem_byte_enable`=2'b11, `mem_wdata`=`req_wdata`.
  - Byte access: `mem_byte_enable` = `req_addr[0]` ? 2'b10 : 2'b01; `mem_wdata`=`{req_wdata[7:0],req_wdata[7:0]}`.
  - Loads drive `mem_byte_enable`=2'b11; the byte is selected on return.
- **Load return:**
  - Word load: `rsp_rdata`=`mem_rdata`.
  - Byte load: the byte selected by `addr[0]` (1 = [15:8]), then extended per `req_signed`.
- **Reset:** state is IDLE. Every output is 0, except `req_ready`, which is 1 once reset is released.
  - The memory has no reset, so reset mid-ACCESS can leave a memory response in flight. The system-level requirement is that reset is held longer than the memory latency.

## Timing
- Request accepted at edge N. `mem_*` strobes are valid after edge N; memory samples them at edge N+1.
- `mem_resp` sampled at edge M: `rsp_valid` is high in cycle M..M+1, and `req_ready` returns after edge M+1.
- Minimum core-visible latency is 3 cycles plus the memory delay. Back-to-back requests are spaced by at least the DONE cycle.
- Misaligned request: `rsp_valid`+`rsp_error` in the cycle after acceptance.
- `req_*` fields are ignored outside the accepting edge.

## Structure
- `mem_req_pkg` holds:
  - the `state_t` enum;
  - the byte-enable constants `BE_WORD`=2'b11, `BE_LO`=2'b01, `BE_HI`=2'b10;
  - the `EXT_ZERO`/`EXT_SIGN` encodings.
- Sub-module `mem_lane_align` (combinational): store steering plus load byte select/extend, shared with future cache fill logic.
- `mem_requester` holds the FSM, request registers, watchdog and response registers.

## Test plan
- **Word load:** memory[0x0010]=0x12, [0x0011]=0x34; word load at 0x0010 → `mem_byte_enable`=11, `mem_address`=0x0010, `rsp_rdata`=0x3412, `rsp_error`=0.
- **Byte store:** byte store 0x00AB to 0x0021 (memory word 0x5566) → `mem_address`=0x0020, `mem_byte_enable`=10, `mem_wdata`=0xABAB. A following word load at 0x0020 returns 0xAB66.
- **Byte load extension:** byte load at 0x0021 (holds 0xAB) → signed returns 0xFFAB, unsigned returns 0x00AB. Byte load at 0x0020 (0x66) signed → 0x0066.
- **Misaligned word:** word load at 0x0033 → `mem_read` never rises; `rsp_valid`+`rsp_error` one cycle after acceptance; `rsp_rdata`=0.
- **Timeout and drain:** `TIMEOUT_CYCLES`=8 with a stub memory that never responds → error pulse 8 cycles after launch, strobes low, `req_ready` low for 8 DRAIN cycles. Repeat with a late `mem_resp` during DRAIN → block returns to IDLE on that edge with no second `rsp_valid`.
- **Reset mid-access:** assert `reset` mid-ACCESS → all outputs 0 immediately (asynchronous). After release, `req_ready`=1 and a new word load completes normally.
